// File: rtl/ads1256_scanner.sv
// ads1256_scanner: round-robin single-ended scanner for an ADS1256 over SPI mode 1,
// one WREG MUX / SYNC / WAKEUP / RDATA / 24-bit read per conversion, one-deep output register.
module ads1256_scanner #(
    parameter int NUM_CH    = 8,
    parameter int CLK_DIV   = 32,
    parameter int T6_CYCLES = 700
) (
    input  logic              clock_i,
    input  logic              reset_L_i,
    input  logic              enable_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    output logic [23:0]       sample_o,
    output logic [2:0]        sample_ch_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              overrun_o,
    input  logic              clear_overrun_i,
    output logic              busy_o,
    input  logic              ADS1256_DRDY,
    input  logic              ADS1256_DOUT,
    output logic              ADS1256_SCLK,
    output logic              ADS1256_DIN,
    output logic              ADS1256_CS
);
    localparam logic [3:0] IDLE = 4'd0, PICK = 4'd1, WAIT_DRDY1 = 4'd2, SEND_CFG = 4'd3,
                           WAIT_DRDY2 = 4'd4, SEND_RDATA = 4'd5, T6_WAIT = 4'd6,
                           READ = 4'd7, DELIVER = 4'd8;
    localparam int DW = $clog2(CLK_DIV);
    localparam int WW = $clog2(T6_CYCLES + 2 * CLK_DIV + 1);

    logic [3:0]    state;
    logic [1:0]    drdy_sync;
    logic [DW-1:0] div_cnt;
    logic [WW-1:0] wait_cnt;
    logic [5:0]    bits_left;
    logic [39:0]   tx;
    logic [23:0]   rx;
    logic [2:0]    ch, nxt_ch;
    logic          seen_high, shifting, tick, shift_done, drdy;

    assign drdy       = drdy_sync[1];
    assign shifting   = state == SEND_CFG || state == SEND_RDATA || state == READ;
    assign tick       = div_cnt == DW'(CLK_DIV - 1);
    assign shift_done = tick && !ADS1256_SCLK && bits_left == 6'd0;
    assign busy_o     = state != IDLE;

    // Lowest set channel overall, overridden by the lowest set channel above the current one.
    always_comb begin
        nxt_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) if (ch_mask_i[i]) nxt_ch = 3'(i);
        for (int i = NUM_CH - 1; i >= 0; i--) if (ch_mask_i[i] && 3'(i) > ch) nxt_ch = 3'(i);
    end

    always_ff @(posedge clock_i or negedge reset_L_i) begin
        if (!reset_L_i) begin
            state          <= IDLE;
            drdy_sync      <= 2'b11;
            div_cnt        <= '0;
            wait_cnt       <= '0;
            bits_left      <= '0;
            tx             <= '0;
            rx             <= '0;
            ch             <= 3'(NUM_CH - 1);
            seen_high      <= 1'b0;
            ADS1256_SCLK   <= 1'b0;
            ADS1256_DIN    <= 1'b0;
            ADS1256_CS     <= 1'b1;
            sample_o       <= '0;
            sample_ch_o    <= '0;
            sample_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            drdy_sync <= {drdy_sync[0], ADS1256_DRDY};
            div_cnt   <= shifting && !tick ? div_cnt + 1'b1 : '0;
            if (sample_valid_o && sample_ready_i) sample_valid_o <= 1'b0;
            if (clear_overrun_i) overrun_o <= 1'b0;
            // Each bit: CLK_DIV low, then rise with new DIN, CLK_DIV high, fall captures DOUT.
            if (shifting && tick) begin
                if (ADS1256_SCLK) begin
                    ADS1256_SCLK <= 1'b0;
                    rx           <= {rx[22:0], ADS1256_DOUT};
                    bits_left    <= bits_left - 1'b1;
                end else if (bits_left != 6'd0) begin
                    ADS1256_SCLK <= 1'b1;
                    ADS1256_DIN  <= tx[39];
                    tx           <= {tx[38:0], 1'b0};
                end
            end
            case (state)
                IDLE: if (enable_i && |ch_mask_i) state <= PICK;
                PICK: begin
                    ch    <= |ch_mask_i ? nxt_ch : ch;
                    state <= |ch_mask_i ? WAIT_DRDY1 : IDLE;
                end
                WAIT_DRDY1: if (!drdy) begin
                    ADS1256_CS <= 1'b0;
                    tx         <= {8'h51, 8'h00, 1'b0, ch, 4'h8, 8'hFC, 8'h00};
                    bits_left  <= 6'd40;
                    state      <= SEND_CFG;
                end
                SEND_CFG: if (shift_done) begin
                    ADS1256_CS <= 1'b1;
                    wait_cnt   <= WW'(2 * CLK_DIV - 1);
                    seen_high  <= 1'b0;
                    state      <= WAIT_DRDY2;
                end
                WAIT_DRDY2: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    if (drdy) seen_high <= 1'b1;
                    if (wait_cnt == '0 && seen_high && !drdy) begin
                        ADS1256_CS <= 1'b0;
                        tx         <= {8'h01, 32'h0};
                        bits_left  <= 6'd8;
                        state      <= SEND_RDATA;
                    end
                end
                SEND_RDATA: if (shift_done) begin
                    wait_cnt <= WW'(T6_CYCLES - 1);
                    state    <= T6_WAIT;
                end
                T6_WAIT: if (wait_cnt == '0) begin
                    ADS1256_DIN <= 1'b0;
                    tx          <= '0;
                    bits_left   <= 6'd24;
                    state       <= READ;
                end else wait_cnt <= wait_cnt - 1'b1;
                READ: if (shift_done) begin
                    ADS1256_CS <= 1'b1;
                    state      <= DELIVER;
                end
                DELIVER: begin
                    if (!sample_valid_o || sample_ready_i) begin
                        sample_o       <= rx;
                        sample_ch_o    <= ch;
                        sample_valid_o <= 1'b1;
                    end else overrun_o <= 1'b1;
                    state <= enable_i ? PICK : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ads1256_scanner.sv
// tb_ads1256_scanner: ADS1256 bus model plus a channel-order/sample scoreboard for ads1256_scanner.
module tb_ads1256_scanner;
    localparam int NUM_CH = 8, CLK_DIV = 4, T6 = 20;

    logic clock_i = 0, reset_L_i = 0, enable_i = 0, sample_ready_i = 0, clear_overrun_i = 0;
    logic [7:0] ch_mask_i = 0;
    logic [23:0] sample_o;
    logic [2:0] sample_ch_o;
    logic sample_valid_o, overrun_o, busy_o, sclk, din, cs;
    logic drdy = 0, dout = 0;

    ads1256_scanner #(.NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .T6_CYCLES(T6)) dut (
        .clock_i(clock_i), .reset_L_i(reset_L_i), .enable_i(enable_i), .ch_mask_i(ch_mask_i),
        .sample_o(sample_o), .sample_ch_o(sample_ch_o), .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i), .overrun_o(overrun_o), .clear_overrun_i(clear_overrun_i),
        .busy_o(busy_o), .ADS1256_DRDY(drdy), .ADS1256_DOUT(dout), .ADS1256_SCLK(sclk),
        .ADS1256_DIN(din), .ADS1256_CS(cs));

    always #5 clock_i = ~clock_i;

    int checks = 0, errors = 0, cyc = 0, prev = -1;
    logic [23:0] adc_val [NUM_CH];
    logic [7:0] din_q [$];
    logic [26:0] got [$];
    logic sclk_p = 0, cs_p = 1, rd_mode = 0, first_rd = 0;
    logic [7:0] sh_in = 0;
    logic [23:0] sh_out = 0;
    logic [2:0] mux_ch = 0;
    int nbits = 0, nbytes = 0, drdy_cnt = 0, n_conv = 0, edges = 0, busy_seen = 0;
    int t_rise = 0, t_fall_rd = 0, hi = 0, hi_min = 999999, hi_max = 0, gap_min = 999999;

    // ADC model: decodes DIN on SCLK falls, serves RDATA on SCLK rises, pulses DRDY after SYNC and reads.
    always @(negedge clock_i) begin
        cyc++;
        if (busy_o) busy_seen++;
        if (sample_valid_o && sample_ready_i) got.push_back({sample_ch_o, sample_o});
        if (drdy_cnt > 0) begin drdy_cnt--; if (drdy_cnt == 0) drdy = 0; end
        if (cs && !cs_p) begin
            if (rd_mode) n_conv++;
            if (rd_mode || nbytes == 5) begin drdy = 1; drdy_cnt = $urandom_range(4, 30); end
            nbits = 0; nbytes = 0; rd_mode = 0; dout = 0;
        end
        if (sclk && !sclk_p) begin
            edges++;
            t_rise = cyc;
            if (rd_mode && first_rd) begin
                first_rd = 0;
                if (cyc - t_fall_rd < gap_min) gap_min = cyc - t_fall_rd;
            end
            if (rd_mode && !cs) begin dout = sh_out[23]; sh_out = sh_out << 1; end
        end
        if (!sclk && sclk_p) begin
            hi = cyc - t_rise;
            if (hi < hi_min) hi_min = hi;
            if (hi > hi_max) hi_max = hi;
            if (!cs && !rd_mode) begin
                sh_in = {sh_in[6:0], din};
                nbits++;
                if (nbits == 8) begin
                    din_q.push_back(sh_in);
                    nbits = 0;
                    if (nbytes == 2) mux_ch = sh_in[6:4];
                    if (nbytes == 0 && sh_in == 8'h01) begin
                        rd_mode = 1; first_rd = 1; sh_out = adc_val[mux_ch]; t_fall_rd = cyc;
                    end
                    nbytes++;
                end
            end
        end
        sclk_p = sclk;
        cs_p = cs;
    end

    function automatic int next_ch(input logic [7:0] m);
        for (int c = prev + 1; c < NUM_CH; c++) if (m[c]) return c;
        for (int c = 0; c < NUM_CH; c++) if (m[c]) return c;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic wait_busy_low(input string name);
        int n = 0;
        while (busy_o && n < 20000) begin tick(); n++; end
        checks++;
        if (busy_o) begin errors++; $display("FAIL %s_idle: busy_o=%b after %0d cycles, required 0", name, busy_o, n); end
    endtask

    task automatic wait_samples(input int k, input string name);
        int n = 0;
        while (got.size() < k && n < 20000) begin tick(); n++; end
        checks++;
        if (got.size() < k) begin errors++; $display("FAIL %s_samples: got %0d samples, required %0d", name, got.size(), k); end
    endtask

    // Scoreboard: each completed conversion must follow the round-robin order with the right command bytes.
    task automatic check_run(input string name, input logic [7:0] m, input int conv, input int deliver);
        logic [26:0] exp_q [$];
        logic [47:0] bytes, want;
        for (int k = 0; k < conv; k++) begin
            int c;
            c = next_ch(m);
            prev = c;
            want = {8'h51, 8'h00, 1'b0, 3'(c), 4'h8, 8'hFC, 8'h00, 8'h01};
            bytes = '0;
            for (int b = 0; b < 6; b++)
                if (din_q.size() > 0) bytes = {bytes[39:0], din_q.pop_front()};
                else bytes = {bytes[39:0], 8'hxx};
            checks++;
            if (bytes !== want) begin errors++; $display("FAIL %s_din%0d: got %h required %h", name, k, bytes, want); end
            if (k < deliver) exp_q.push_back({3'(c), adc_val[c]});
        end
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL %s_count: got %0d samples, required %0d", name, got.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin errors++; $display("FAIL %s_sample%0d: got ch%0d %h required ch%0d %h", name, i, got[i][26:24], got[i][23:0], exp_q[i][26:24], exp_q[i][23:0]); end
            end
        end
        got.delete();
        din_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks += 8;
        if (cs !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b required 1", cs); end
        if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b required 0", sclk); end
        if (din !== 1'b0) begin errors++; $display("FAIL rst_din: got %b required 0", din); end
        if (sample_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", sample_valid_o); end
        if (overrun_o !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b required 0", overrun_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy_o); end
        if (sample_o !== 24'h0) begin errors++; $display("FAIL rst_sample: got %h required 0", sample_o); end
        if (sample_ch_o !== 3'h0) begin errors++; $display("FAIL rst_ch: got %h required 0", sample_ch_o); end
        reset_L_i = 1;
        repeat (3) tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_idle: busy_o=%b required 0", busy_o); end
    endtask

    task automatic test_scan_basic();
        int n0 = n_conv;
        foreach (adc_val[i]) adc_val[i] = 24'($urandom);
        adc_val[0] = 24'h7FFFFF;
        adc_val[2] = 24'h800000;
        hi_min = 999999; hi_max = 0; gap_min = 999999;
        ch_mask_i = 8'h05; sample_ready_i = 1; enable_i = 1;
        wait_samples(3, "basic");
        enable_i = 0;
        wait_busy_low("basic");
        repeat (2) tick();
        checks += 3;
        if (got.size() < 3 || got[0] !== {3'd0, 24'h7FFFFF}) begin errors++; $display("FAIL basic_s0: first sample wrong, required ch0 7fffff"); end
        if (got.size() < 3 || got[1] !== {3'd2, 24'h800000}) begin errors++; $display("FAIL basic_s1: second sample wrong, required ch2 800000"); end
        if (got.size() < 3 || got[2] !== {3'd0, 24'h7FFFFF}) begin errors++; $display("FAIL basic_s2: third sample wrong, required ch0 7fffff"); end
        checks += 4;
        if (hi_min != CLK_DIV) begin errors++; $display("FAIL basic_sclk_hi_min: got %0d required %0d", hi_min, CLK_DIV); end
        if (hi_max != CLK_DIV) begin errors++; $display("FAIL basic_sclk_hi_max: got %0d required %0d", hi_max, CLK_DIV); end
        if (gap_min < T6) begin errors++; $display("FAIL basic_t6: got %0d required >=%0d", gap_min, T6); end
        if (cs !== 1'b1) begin errors++; $display("FAIL basic_cs_idle: got %b required 1", cs); end
        check_run("basic", 8'h05, n_conv - n0, n_conv - n0);
    endtask

    task automatic test_random_scan();
        for (int r = 0; r < 2; r++) begin
            int n0 = n_conv, n = 0;
            logic [7:0] m = 8'($urandom_range(1, 255));
            foreach (adc_val[i]) adc_val[i] = 24'($urandom);
            ch_mask_i = m; enable_i = 1;
            while (got.size() < 4 && n < 20000) begin
                tick();
                sample_ready_i = $urandom_range(0, 3) != 0;
                n++;
            end
            enable_i = 0; sample_ready_i = 1;
            wait_busy_low("random");
            repeat (3) tick();
            checks++;
            if (overrun_o !== 1'b0) begin errors++; $display("FAIL random_overrun: got %b required 0", overrun_o); end
            check_run("random", m, n_conv - n0, n_conv - n0);
        end
    endtask

    task automatic test_overrun();
        int n0 = n_conv, n = 0;
        logic [26:0] held;
        logic [7:0] m = 8'($urandom_range(1, 255));
        foreach (adc_val[i]) adc_val[i] = 24'($urandom);
        ch_mask_i = m; sample_ready_i = 0; enable_i = 1;
        while (!sample_valid_o && n < 20000) begin tick(); n++; end
        held = {sample_ch_o, sample_o};
        n = 0;
        while (!overrun_o && n < 20000) begin tick(); n++; end
        checks += 3;
        if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b required 1", overrun_o); end
        if (sample_valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b required 1", sample_valid_o); end
        if ({sample_ch_o, sample_o} !== held) begin errors++; $display("FAIL ovr_hold: got %h required %h", {sample_ch_o, sample_o}, held); end
        enable_i = 0;
        wait_busy_low("ovr");
        clear_overrun_i = 1;
        tick();
        clear_overrun_i = 0;
        checks += 2;
        if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b required 0", overrun_o); end
        if ({sample_ch_o, sample_o} !== held) begin errors++; $display("FAIL ovr_hold2: got %h required %h", {sample_ch_o, sample_o}, held); end
        sample_ready_i = 1;
        repeat (2) tick();
        check_run("ovr", m, n_conv - n0, 1);
    endtask

    task automatic test_enable_drop();
        int n0 = n_conv, n = 0, lows = 0;
        logic [7:0] m = 8'($urandom_range(1, 255));
        foreach (adc_val[i]) adc_val[i] = 24'($urandom);
        ch_mask_i = m; sample_ready_i = 1; enable_i = 1;
        while (!rd_mode && n < 20000) begin tick(); n++; end
        repeat (T6 + 4 * CLK_DIV) tick();
        enable_i = 0;
        wait_busy_low("endrop");
        repeat (200) begin tick(); if (!cs) lows++; end
        checks += 3;
        if (n_conv - n0 != 1) begin errors++; $display("FAIL endrop_conv: got %0d conversions required 1", n_conv - n0); end
        if (lows != 0) begin errors++; $display("FAIL endrop_cs: CS low for %0d cycles, required 0", lows); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL endrop_busy: got %b required 0", busy_o); end
        check_run("endrop", m, n_conv - n0, n_conv - n0);
    endtask

    task automatic test_mask_zero();
        int e0 = edges, b0 = busy_seen;
        ch_mask_i = 8'h00; enable_i = 1;
        repeat (200) tick();
        enable_i = 0;
        checks += 2;
        if (busy_seen != b0) begin errors++; $display("FAIL mask0_busy: busy high %0d cycles, required 0", busy_seen - b0); end
        if (edges != e0) begin errors++; $display("FAIL mask0_sclk: got %0d SCLK edges, required 0", edges - e0); end
    endtask

    task automatic test_reset_mid();
        int n0 = n_conv, n = 0, low;
        logic [7:0] m = 8'($urandom_range(1, 127)) | 8'h80;
        foreach (adc_val[i]) adc_val[i] = 24'($urandom);
        ch_mask_i = m; sample_ready_i = 1; enable_i = 1;
        wait_samples(1, "rstmid");
        while (!(nbytes >= 1 && !cs && !rd_mode) && n < 20000) begin tick(); n++; end
        @(posedge clock_i);
        #3 reset_L_i = 0;
        #1;
        checks += 3;
        if (cs !== 1'b1) begin errors++; $display("FAIL rstmid_cs: got %b required 1", cs); end
        if (sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b required 0", sclk); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy_o); end
        repeat (2) tick();
        check_run("rstmid_pre", m, n_conv - n0, n_conv - n0);
        prev = -1;
        low = next_ch(m);
        n0 = n_conv;
        reset_L_i = 1;
        wait_samples(2, "rstmid");
        enable_i = 0;
        wait_busy_low("rstmid");
        repeat (2) tick();
        checks++;
        if (got.size() == 0 || got[0][26:24] !== 3'(low)) begin errors++; $display("FAIL rstmid_restart: first channel after reset wrong, required %0d", low); end
        check_run("rstmid", m, n_conv - n0, n_conv - n0);
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_random_scan();
        test_overrun();
        test_enable_drop();
        test_mask_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ads1256_scanner.md
ADS1256_SCANNER -- requirements
Module: ads1256_scanner

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8, meaning the number of AINx channels scanned against AINCOM (legal 1..8).
REQ-002 The block SHALL have parameter CLK_DIV, default 32, meaning clock_i cycles per SCLK half-period (legal >=2).
REQ-003 The block SHALL have parameter T6_CYCLES, default 700, meaning clock_i cycles from the RDATA last falling edge to the first read edge (legal >=1).
REQ-004 The block SHALL have port clock_i, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 The block SHALL have port reset_L_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable_i, input, 1 bit: scanning is requested while high.
REQ-007 The block SHALL have port ch_mask_i, input, NUM_CH bits: bit n set means channel n is scanned.
REQ-008 The block SHALL have port sample_o, output, 24 bits: two's-complement conversion result.
REQ-009 The block SHALL have port sample_ch_o, output, 3 bits: channel index of sample_o.
REQ-010 The block SHALL have port sample_valid_o, output, 1 bit: sample_o and sample_ch_o are valid.
REQ-011 The block SHALL have port sample_ready_i, input, 1 bit: consumer accepts the sample.
REQ-012 The block SHALL have port overrun_o, output, 1 bit: sticky flag, set when a sample was dropped.
REQ-013 The block SHALL have port clear_overrun_i, input, 1 bit: synchronous clear of overrun_o.
REQ-014 The block SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-015 The block SHALL have ports ADS1256_DRDY (input), ADS1256_DOUT (input, MISO), ADS1256_SCLK (output), ADS1256_DIN (output, MOSI) and ADS1256_CS (output, active-low), each 1 bit.

Function
REQ-016 ADS1256_DRDY SHALL pass through a 2-flop synchronizer; "DRDY low" always means the synchronized value.
REQ-017 SPI SHALL be mode 1, MSB first: SCLK idle low; DIN changes on the SCLK rising edge; DOUT is sampled on the SCLK falling edge; each SCLK level lasts CLK_DIV cycles.
REQ-018 FSM states SHALL be IDLE, PICK, WAIT_DRDY1, SEND_CFG, WAIT_DRDY2, SEND_RDATA, T6_WAIT, READ and DELIVER.
REQ-019 IDLE SHALL go to PICK when enable_i is high and ch_mask_i is nonzero; otherwise it stays in IDLE.
REQ-020 PICK SHALL latch the mask and select the lowest set channel strictly above the previous channel, wrapping to the lowest set channel; after reset the search starts at channel 0.
REQ-021 WAIT_DRDY1 SHALL wait for DRDY low, then assert CS low and go to SEND_CFG.
REQ-022 SEND_CFG SHALL shift the bytes 0x51, 0x00, {ch[3:0],4'h8}, 0xFC, 0x00 (WREG MUX, SYNC, WAKEUP) back-to-back, then raise CS for 2*CLK_DIV cycles.
REQ-023 WAIT_DRDY2 SHALL wait for DRDY high then low, then assert CS low.
REQ-024 SEND_RDATA SHALL shift the byte 0x01; T6_WAIT SHALL then hold SCLK low for T6_CYCLES cycles.
REQ-025 READ SHALL clock in 24 bits with DIN held at 0, then raise CS.
REQ-026 DELIVER SHALL last one cycle, handle the captured sample per REQ-027/028, then go to PICK if enable_i is high, else to IDLE.
REQ-027 Handshake: the output register is one-deep; a transfer occurs when sample_valid_o and sample_ready_i are both high; outputs SHALL be stable while valid is high and not ready.
REQ-028 In DELIVER, if the register is empty or transferring that cycle, load the new sample and set valid; otherwise drop the new sample and set overrun_o.
REQ-029 If overrun set and clear_overrun_i occur in the same cycle, set SHALL win.
REQ-030 Deasserting enable_i mid-conversion SHALL NOT abort the conversion; the conversion completes and is delivered.
REQ-031 Changes to ch_mask_i SHALL take effect only at the next PICK.
REQ-032 If the mask latched at PICK is zero, the FSM SHALL return to IDLE.

Reset
REQ-033 While reset_L_i is low, the block SHALL be in IDLE with CS=1, SCLK=0, DIN=0, sample_valid_o=0, overrun_o=0, busy_o=0, sample_o=0, sample_ch_o=0, and the synchronizer flops at 1.
REQ-034 Reset mid-transfer SHALL take effect immediately and asynchronously on all outputs; deassertion is synchronized to clock_i.

Verification
REQ-035 The bench SHALL cover: NUM_CH=8, mask 0x05, ADC model returns 0x7FFFFF for ch0 and 0x800000 for ch2 -> samples (0x7FFFFF,ch0), (0x800000,ch2), (0x7FFFFF,ch0) in that order.
REQ-036 The bench SHALL cover: for each conversion, the DIN bytes are 0x51,0x00,0x08 for ch0 (0x28 for ch2), then 0xFC,0x00, then 0x01; SCLK high time is exactly CLK_DIV cycles; the gap from the RDATA last falling edge to the first read rising edge is >=T6_CYCLES.
REQ-037 The bench SHALL cover: sample_ready_i held low for two conversions -> the first sample is held unchanged, the second is dropped, overrun_o=1; a clear_overrun_i pulse -> overrun_o=0.
REQ-038 The bench SHALL cover: enable_i dropped during READ -> that sample is delivered, then busy_o=0 and CS stays high.
REQ-039 The bench SHALL cover: mask 0x00 with enable_i=1 -> busy_o stays 0 and no SCLK edges occur.
REQ-040 The bench SHALL cover: reset_L_i pulsed low during SEND_CFG -> CS=1 and SCLK=0 in the same cycle; after release, scanning restarts at the lowest enabled channel.
